// File: rtl/nibble_serial_adder_ctrl_if.sv
// nibble_serial_adder_ctrl_if
//   Request/response bundle for the nibble-serial add/subtract sequencer.
//   Request side : in_valid, in_ready, a, b, op_sub
//   Response side: out_valid, out_ready, sum (W+1 bits, MSB = final carry)
//   Status       : busy
//   master modport: the requester/consumer; slave modport: the sequencer.
interface nibble_serial_adder_ctrl_if #(
   parameter int unsigned NIBBLES = 4
);
   localparam int unsigned W = 4 * NIBBLES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         op_sub;
   logic         busy;
   logic         out_valid;
   logic         out_ready;
   logic [W:0]   sum;

   modport master (
      output in_valid, a, b, op_sub, out_ready,
      input  in_ready, busy, out_valid, sum
   );

   modport slave (
      input  in_valid, a, b, op_sub, out_ready,
      output in_ready, busy, out_valid, sum
   );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//   Computes W-bit add/subtract (W = 4*NIBBLES) by stepping a single 4-bit
//   adder slice across the operands, LSB nibble first, one nibble per cycle,
//   with the inter-nibble carry held in a register.
//   Ports:
//     clk  - single clock, rising edge
//     rst  - asynchronous reset, active-high
//     bus  - slave side of nibble_serial_adder_ctrl_if (request handshake,
//            response handshake, busy status, W+1 bit result)
//   Sequence: IDLE --accept--> RUN (NIBBLES edges) --> DONE --out_ready--> IDLE
module nibble_serial_adder_ctrl #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   nibble_serial_adder_ctrl_if.slave  bus
);
   localparam int unsigned W  = 4 * NIBBLES;
   localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_n;

   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;          // already inverted for subtract
   logic          carry;
   logic [CW-1:0] cnt;
   logic [W:0]    sum_q;

   logic          accept;
   logic          last;
   logic          in_ready_c;
   logic          busy_c;
   logic          out_valid_c;

   logic [3:0]    a_nib;
   logic [3:0]    b_nib;
   logic [4:0]    slice;

   assign last = (cnt == CW'(NIBBLES - 1));

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and handshake outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_n     = state;
      accept      = 1'b0;
      in_ready_c  = 1'b0;
      busy_c      = 1'b0;
      out_valid_c = 1'b0;
      unique case (state)
         S_IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               accept  = 1'b1;
               state_n = S_RUN;
            end
         end
         S_RUN: begin
            busy_c = 1'b1;
            if (last) begin
               state_n = S_DONE;
            end
         end
         S_DONE: begin
            busy_c      = 1'b1;
            out_valid_c = 1'b1;
            if (bus.out_ready) begin
               state_n = S_IDLE;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Nibble select: a constant-index mux keeps every part-select static
   // ------------------------------------------------------------------
   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int unsigned i = 0; i < NIBBLES; i++) begin
         if (cnt == CW'(i)) begin
            a_nib = a_q[4*i +: 4];
            b_nib = b_q[4*i +: 4];
         end
      end
   end

   // The single 4-bit adder slice shared by every nibble position.
   assign slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum_q <= '0;
      end else if (accept) begin
         // Subtract is A + ~B + 1: invert B once here and seed the carry.
         a_q   <= bus.a;
         b_q   <= bus.op_sub ? ~bus.b : bus.b;
         carry <= bus.op_sub;
         cnt   <= '0;
         sum_q <= '0;
      end else if (state == S_RUN) begin
         carry <= slice[4];
         for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) begin
               sum_q[4*i +: 4] <= slice[3:0];
            end
         end
         if (last) begin
            // Hold cnt at its final value so it never exceeds NIBBLES-1.
            sum_q[W] <= slice[4];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.busy      = busy_c;
   assign bus.out_valid = out_valid_c;
   assign bus.sum       = sum_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl
//   Self-checking bench for nibble_serial_adder_ctrl with NIBBLES=4.
//   A negedge monitor pushes the expected result of every accepted request
//   onto a queue and pops/compares it at each output handshake; scenario
//   tasks add their own timing and status checks.
`timescale 1ns/1ps
module tb_nibble_serial_adder_ctrl;
   localparam int unsigned NIBBLES = 4;
   localparam int unsigned W = 4 * NIBBLES;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;
   int unsigned lat;
   logic        prev_valid = 1'b0;

   logic [W:0]  exp_q[$];
   int unsigned acc_pending[$];
   int unsigned acc_log[$];

   nibble_serial_adder_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

   nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic sub);
      logic [W:0] xe, ye, one;
      xe  = {1'b0, x};
      one = 1;
      if (sub) begin
         ye = {1'b0, ~y};
         return xe + ye + one;
      end
      ye = {1'b0, y};
      return xe + ye;
   endfunction

   // Scoreboard / latency monitor, sampling mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.a, bus.b, bus.op_sub));
            acc_pending.push_back(cyc + 1);
            acc_log.push_back(cyc + 1);
         end
         if (bus.out_valid && !prev_valid) begin
            checks++;
            if (acc_pending.size() == 0) begin
               failures++;
               $display("FAIL latency: out_valid rose with no pending accept");
            end else begin
               lat = cyc - acc_pending.pop_front();
               if (lat !== NIBBLES) begin
                  failures++;
                  $display("FAIL latency: got %0d edges expected %0d", lat, NIBBLES);
               end
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL scoreboard: unexpected result %h", bus.sum);
            end else begin
               logic [W:0] e;
               e = exp_q.pop_front();
               if (bus.sum !== e) begin
                  failures++;
                  $display("FAIL scoreboard: sum got %h expected %h", bus.sum, e);
               end
            end
         end
         prev_valid = bus.out_valid;
      end
   end

   // Drive one request once in_ready is seen; returns at accept edge + #1.
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub,
                        output bit to);
      int n = 0;
      to = 1'b0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) begin
         to = 1'b1;
         return;
      end
      bus.a = x; bus.b = y; bus.op_sub = sub; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n, output bit to);
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      to = (n >= 50);
   endtask

   task automatic test_reset;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op_sub = 1'b0; bus.out_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      checks++;
      if (bus.sum !== '0) begin failures++; $display("FAIL reset_sum: got %h expected 0", bus.sum); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_add_basic;
      bit to; int n;
      bus.out_ready = 1'b1;
      issue(16'h1234, 16'h0FFF, 1'b0, to);
      wait_valid(n, to);
      checks++;
      if (to || n != NIBBLES) begin failures++; $display("FAIL add_latency: got %0d expected %0d", n, NIBBLES); end
      checks++;
      if (bus.sum !== 17'h02233) begin failures++; $display("FAIL add_sum: got %h expected 02233", bus.sum); end
      checks++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
         failures++; $display("FAIL add_status: busy %b in_ready %b expected 1 0", bus.busy, bus.in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL add_release: out_valid %b in_ready %b expected 0 1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_carry_ripple;
      bit to; int n;
      bus.out_ready = 1'b1;
      issue(16'hFFFF, 16'h0001, 1'b0, to);
      wait_valid(n, to);
      checks++;
      if (to || bus.sum !== 17'h10000) begin failures++; $display("FAIL carry_sum: got %h expected 10000", bus.sum); end
      @(posedge clk); #1;
   endtask

   task automatic test_subtract;
      bit to; int n;
      logic [W-1:0] ta[2], tb[2];
      logic [W:0]   te[2];
      ta[0] = 16'h1000; tb[0] = 16'h0001; te[0] = 17'h10FFF;
      ta[1] = 16'h0001; tb[1] = 16'h0002; te[1] = 17'h0FFFF;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         issue(ta[i], tb[i], 1'b1, to);
         wait_valid(n, to);
         checks++;
         if (to || bus.sum !== te[i]) begin
            failures++; $display("FAIL sub_sum[%0d]: got %h expected %h", i, bus.sum, te[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure;
      bit to; int n;
      bus.out_ready = 1'b0;
      issue(16'hABCD, 16'h1111, 1'b0, to);
      wait_valid(n, to);
      checks++;
      if (to) begin failures++; $display("FAIL bp_timeout: out_valid never rose"); end
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.a = W'($urandom);
         bus.b = W'($urandom);
         bus.op_sub = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.sum !== 17'h0BCDE) begin
            failures++;
            $display("FAIL bp_hold[%0d]: out_valid %b in_ready %b sum %h expected 1 0 0bcde",
                     i, bus.out_valid, bus.in_ready, bus.sum);
         end
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL bp_release: out_valid %b in_ready %b expected 0 1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset_abort;
      bit to; int n; bit seen;
      bus.out_ready = 1'b1;
      issue(16'h1111, 16'h2222, 1'b0, to);
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if (bus.busy !== 1'b1) begin failures++; $display("FAIL abort_busy: got %b expected 1", bus.busy); end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.sum !== '0) begin
         failures++;
         $display("FAIL abort_outputs: in_ready %b busy %b out_valid %b sum %h expected 1 0 0 0",
                  bus.in_ready, bus.busy, bus.out_valid, bus.sum);
      end
      exp_q.delete();
      acc_pending.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) begin failures++; $display("FAIL abort_no_valid: got out_valid 1 expected 0"); end
      issue(16'h0001, 16'h0001, 1'b0, to);
      wait_valid(n, to);
      checks++;
      if (to || bus.sum !== 17'h00002) begin failures++; $display("FAIL abort_next_sum: got %h expected 00002", bus.sum); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      int unsigned start;
      int n;
      bus.out_ready = 1'b1;
      start = acc_log.size();
      bus.a = W'($urandom); bus.b = W'($urandom); bus.op_sub = 1'($urandom_range(0, 1));
      bus.in_valid = 1'b1;
      n = 0;
      while (acc_log.size() - start < 3 && n < 60) begin
         @(posedge clk); #1;
         n++;
         bus.a = W'($urandom); bus.b = W'($urandom); bus.op_sub = 1'($urandom_range(0, 1));
      end
      bus.in_valid = 1'b0;
      checks++;
      if (acc_log.size() - start < 3) begin
         failures++; $display("FAIL b2b_accepts: got %0d expected 3", acc_log.size() - start);
      end else begin
         for (int unsigned i = 1; i < 3; i++) begin
            checks++;
            if (acc_log[start+i] - acc_log[start+i-1] !== NIBBLES + 2) begin
               failures++;
               $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", i,
                        acc_log[start+i] - acc_log[start+i-1], NIBBLES + 2);
            end
         end
      end
      n = 0;
      while ((exp_q.size() != 0 || bus.in_ready !== 1'b1) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n >= 50) begin failures++; $display("FAIL b2b_drain: got %0d pending expected 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_add_basic();
      test_carry_ripple();
      test_subtract();
      test_backpressure();
      test_reset_abort();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin
         failures++; $display("FAIL final_queue: got %0d pending expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
